e203_exu_dsp_add64: RTL and testbench

Two-beat operand collector and sequencer for 64-bit DSP add/sub (ADD64, SUB64, KADD64, KSUB64).
- Sits directly upstream of the combinational `e203_exu_dsp_adder` and owns it.
- Gathers register-pair operands from the 32-bit EXU issue path in two beats, low halves then high halves.
- Inverts op2 for subtraction and drives the big/little adder as one carry-chained 64-bit add.
- Applies signed saturation and hands a registered 64-bit result to write-back over valid/ready.

---
 rtl/e203_exu_dsp_add64_pkg.sv | 38 +++
 rtl/e203_exu_dsp_adder.sv | 54 +++++
 rtl/e203_exu_dsp_add64.sv | 199 +++++++++++++++++++
 tb/tb_e203_exu_dsp_add64.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_dsp_add64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_dsp_add64_pkg
// Description : Shared constants for the 64-bit DSP add/sub path.
//               - Opcode encodings for ADD64 / SUB64 / KADD64 / KSUB64.
//               - Big (low half) and little (high half) adder widths.
//               - Signed 64-bit saturation bounds.
//               - Small opcode decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package e203_exu_dsp_add64_pkg;

  // Adder widths: 32 data bits plus one extension bit.
  // Big adder: bit 32 is the carry-out into the little adder.
  // Little adder: bit 32 is the sign extension used for overflow detection.
  localparam int E203_DSP_BIGADDER_WIDTH = 33;
  localparam int E203_DSP_LITADDER_WIDTH = 33;

  // Opcode encodings. Bit 0 selects subtraction, bit 1 selects saturation.
  localparam logic [1:0] E203_DSP_OP_ADD64  = 2'b00;
  localparam logic [1:0] E203_DSP_OP_SUB64  = 2'b01;
  localparam logic [1:0] E203_DSP_OP_KADD64 = 2'b10;
  localparam logic [1:0] E203_DSP_OP_KSUB64 = 2'b11;

  // Signed 64-bit saturation bounds.
  localparam logic [63:0] E203_DSP_SAT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] E203_DSP_SAT64_MIN = 64'h8000_0000_0000_0000;

  function automatic logic dsp_op_is_sub(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic dsp_op_is_sat(input logic [1:0] op);
    return op[1];
  endfunction

endpackage : e203_exu_dsp_add64_pkg
`default_nettype wire

// File: rtl/e203_exu_dsp_adder.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_dsp_adder
// Description : Combinational carry-chained big/little adder pair.
//               The big adder sums the low halves with carry-in equal to the
//               subtract enable; its carry-out (bit 32) feeds the little
//               adder, which sums the sign-extended high halves.
//               With dsp_req_addsub_i low both results are forced to zero.
// Ports       :
//   dsp_req_addsub_i  in   1   adder request; outputs are 0 when low
//   dsp_req_sub_en_i  in   1   subtract: supplies the +1 carry-in
//   big_op1_i         in   33  low-half operand 1 {1'b0, rs1_lo}
//   big_op2_i         in   33  low-half operand 2 {1'b0, rs2_lo^sub}
//   lit_op1_i         in   33  high-half operand 1, sign-extended
//   lit_op2_i         in   33  high-half operand 2, sign-extended
//   big_res_o         out  32  low-half sum (carry-out stays internal)
//   lit_res_o         out  33  high-half sum including extension bit
// Revision    : 1.0 - initial release
// ============================================================================
module e203_exu_dsp_adder
  import e203_exu_dsp_add64_pkg::*;
(
  input  logic                               dsp_req_addsub_i,
  input  logic                               dsp_req_sub_en_i,
  input  logic [E203_DSP_BIGADDER_WIDTH-1:0] big_op1_i,
  input  logic [E203_DSP_BIGADDER_WIDTH-1:0] big_op2_i,
  input  logic [E203_DSP_LITADDER_WIDTH-1:0] lit_op1_i,
  input  logic [E203_DSP_LITADDER_WIDTH-1:0] lit_op2_i,
  output logic [E203_DSP_BIGADDER_WIDTH-2:0] big_res_o,
  output logic [E203_DSP_LITADDER_WIDTH-1:0] lit_res_o
);

  localparam int BW = E203_DSP_BIGADDER_WIDTH;
  localparam int LW = E203_DSP_LITADDER_WIDTH;

  logic [BW-1:0] big_sum;
  logic [LW-1:0] lit_sum;

  always_comb begin
    big_sum = '0;
    lit_sum = '0;
    if (dsp_req_addsub_i) begin
      // Operands have a zero top bit, so the 33-bit sum cannot wrap.
      big_sum = big_op1_i + big_op2_i + {{(BW-1){1'b0}}, dsp_req_sub_en_i};
      // Low-half carry-out chains into the high half.
      lit_sum = lit_op1_i + lit_op2_i + {{(LW-1){1'b0}}, big_sum[BW-1]};
    end
  end

  assign big_res_o = big_sum[BW-2:0];
  assign lit_res_o = lit_sum;

endmodule : e203_exu_dsp_adder
`default_nettype wire

// File: rtl/e203_exu_dsp_add64.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_dsp_add64
// Description : Two-beat operand collector and sequencer for 64-bit DSP
//               add/sub (ADD64, SUB64, KADD64, KSUB64). Collects low halves
//               on beat 0 and high halves on beat 1, runs one carry-chained
//               64-bit add through e203_exu_dsp_adder, applies signed
//               saturation for K ops and returns a registered result.
// Ports       :
//   clk      in   1   core clock
//   rst      in   1   synchronous active-high reset (priority over flush)
//   i_valid  in   1   operand beat valid
//   i_ready  out  1   operand beat accepted when i_valid & i_ready
//   i_op     in   2   opcode, sampled on beat 0 only
//   i_rs1    in   32  op1 half (low on beat 0, high on beat 1)
//   i_rs2    in   32  op2 half (low on beat 0, high on beat 1)
//   flush    in   1   abort in-flight op, return to IDLE
//   o_valid  out  1   result valid
//   o_ready  in   1   write-back accepts result
//   o_res    out  64  result
//   o_ov     out  1   saturation occurred (K ops only)
// Revision    : 1.0 - initial release
// ============================================================================
module e203_exu_dsp_add64
  import e203_exu_dsp_add64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        flush,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [63:0] o_res,
  output logic        o_ov
);

  localparam int BW = E203_DSP_BIGADDER_WIDTH;
  localparam int LW = E203_DSP_LITADDER_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_EXE  = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  logic [1:0]  state_q,  state_d;
  logic [1:0]  op_q,     op_d;
  logic [31:0] rs1_lo_q, rs1_lo_d;
  logic [31:0] rs2_lo_q, rs2_lo_d;
  logic [31:0] rs1_hi_q, rs1_hi_d;
  logic [31:0] rs2_hi_q, rs2_hi_d;
  logic [63:0] res_q,    res_d;
  logic        ov_q,     ov_d;

  logic        beat_fire;
  logic        rsp_fire;

  logic                adder_addsub;
  logic                adder_sub;
  logic [BW-1:0]       big_op1;
  logic [BW-1:0]       big_op2;
  logic [LW-1:0]       lit_op1;
  logic [LW-1:0]       lit_op2;
  logic [BW-2:0]       big_res;
  logic [LW-1:0]       lit_res;
  logic [31:0]         rs2_hi_x;
  logic [63:0]         raw_res;
  logic                ovf;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rs1_lo_q <= '0;
      rs2_lo_q <= '0;
      rs1_hi_q <= '0;
      rs2_hi_q <= '0;
      res_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_lo_q <= rs1_lo_d;
      rs2_lo_q <= rs2_lo_d;
      rs1_hi_q <= rs1_hi_d;
      rs2_hi_q <= rs2_hi_d;
      res_q    <= res_d;
      ov_q     <= ov_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (beat_fire) state_d = ST_HI;
        ST_HI:   if (beat_fire) state_d = ST_EXE;
        ST_EXE:  state_d = ST_RSP;
        ST_RSP:  if (rsp_fire) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output / handshake logic
  // --------------------------------------------------------------------------
  always_comb begin
    i_ready      = ((state_q == ST_IDLE) || (state_q == ST_HI)) && !flush;
    o_valid      = (state_q == ST_RSP) && !flush;
    adder_addsub = (state_q == ST_EXE);
  end

  // i_ready and o_valid already include ~flush, so a flushed beat or
  // result never fires.
  assign beat_fire = i_valid & i_ready;
  assign rsp_fire  = o_valid & o_ready;

  assign o_res = res_q;
  assign o_ov  = ov_q;

  // --------------------------------------------------------------------------
  // Operand capture
  // --------------------------------------------------------------------------
  always_comb begin
    op_d     = op_q;
    rs1_lo_d = rs1_lo_q;
    rs2_lo_d = rs2_lo_q;
    rs1_hi_d = rs1_hi_q;
    rs2_hi_d = rs2_hi_q;
    if (beat_fire && (state_q == ST_IDLE)) begin
      op_d     = i_op;
      rs1_lo_d = i_rs1;
      rs2_lo_d = i_rs2;
    end
    if (beat_fire && (state_q == ST_HI)) begin
      rs1_hi_d = i_rs1;
      rs2_hi_d = i_rs2;
    end
  end

  // --------------------------------------------------------------------------
  // Adder drive: subtraction is a + ~b + 1, the +1 entering as the big
  // adder's carry-in.
  // --------------------------------------------------------------------------
  always_comb begin
    adder_sub = adder_addsub & dsp_op_is_sub(op_q);
    rs2_hi_x  = rs2_hi_q ^ {32{adder_sub}};
    big_op1   = {1'b0, rs1_lo_q};
    big_op2   = {1'b0, rs2_lo_q ^ {32{adder_sub}}};
    lit_op1   = {rs1_hi_q[31], rs1_hi_q};
    lit_op2   = {rs2_hi_x[31], rs2_hi_x};
  end

  e203_exu_dsp_adder u_adder (
    .dsp_req_addsub_i (adder_addsub),
    .dsp_req_sub_en_i (adder_sub),
    .big_op1_i        (big_op1),
    .big_op2_i        (big_op2),
    .lit_op1_i        (lit_op1),
    .lit_op2_i        (lit_op2),
    .big_res_o        (big_res),
    .lit_res_o        (lit_res)
  );

  // --------------------------------------------------------------------------
  // Result formation and saturation
  // --------------------------------------------------------------------------
  always_comb begin
    raw_res = {lit_res[LW-2:0], big_res};
    // Sign extension bit disagrees with the result sign on signed overflow.
    ovf     = lit_res[LW-1] ^ lit_res[LW-2];
    res_d   = res_q;
    ov_d    = ov_q;
    if ((state_q == ST_EXE) && !flush) begin
      if (dsp_op_is_sat(op_q) && ovf) begin
        // Extension bit carries the true sign of the overflowed result.
        res_d = lit_res[LW-1] ? E203_DSP_SAT64_MIN : E203_DSP_SAT64_MAX;
        ov_d  = 1'b1;
      end else begin
        res_d = raw_res;
        ov_d  = 1'b0;
      end
    end
  end

endmodule : e203_exu_dsp_add64
`default_nettype wire

// File: tb/tb_e203_exu_dsp_add64.sv
`default_nettype none
// ============================================================================
// Module      : tb_e203_exu_dsp_add64
// Description : Self-checking bench for e203_exu_dsp_add64. Expected results
//               are pushed to a scoreboard queue when an op is issued and
//               popped by a monitor on each result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e203_exu_dsp_add64;

  typedef struct packed {
    logic [63:0] res;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        flush;
  logic        o_valid;
  logic        o_ready;
  logic [63:0] o_res;
  logic        o_ov;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  e203_exu_dsp_add64 dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_op    (i_op),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .flush   (flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_res   (o_res),
    .o_ov    (o_ov)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: 65-bit signed arithmetic, saturate on K ops.
  function automatic exp_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] sa;
    logic signed [64:0] sb;
    logic signed [64:0] r;
    exp_t e;
    sa = {a[63], a};
    sb = {b[63], b};
    r  = op[0] ? (sa - sb) : (sa + sb);
    e.res = r[63:0];
    e.ov  = 1'b0;
    if (op[1] && (r[64] != r[63])) begin
      e.ov  = 1'b1;
      e.res = r[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end
    return e;
  endfunction

  // Result monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_o_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("o_res", o_res, mon_e.res);
        check("o_ov", {63'd0, o_ov}, {63'd0, mon_e.ov});
      end
    end
  end

  // Present one beat and wait (bounded) for acceptance.
  task automatic beat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int cnt;
    i_valid = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    ok      = 1'b0;
    cnt     = 0;
    while (!ok && cnt < 20) begin
      @(negedge clk);
      if (i_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      cnt++;
    end
    i_valid = 1'b0;
    if (!ok) check("beat_timeout", 64'd0, 64'd1);
  endtask

  // Issue a full op; checks the 2-cycle latency from beat 1 to o_valid.
  // Returns one cycle after o_valid first rises (in IDLE if o_ready=1,
  // still in RSP if o_ready=0).
  task automatic send_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    bit ok0;
    bit ok1;
    sb_q.push_back(model(op, a, b));
    beat(op, a[31:0], b[31:0], ok0);
    beat(2'b00, a[63:32], b[63:32], ok1);
    if (!(ok0 && ok1)) begin
      void'(sb_q.pop_back());
    end else begin
      @(negedge clk);
      check("lat_exe_o_valid", {63'd0, o_valid}, 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("lat_rsp_o_valid", {63'd0, o_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e_bp;
    bit   ok;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_rs1   = '0;
    i_rs2   = '0;
    flush   = 1'b0;
    o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_i_ready", {63'd0, i_ready}, 64'd1);
    check("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_o_res", o_res, 64'd0);
    check("rst_o_ov", {63'd0, o_ov}, 64'd0);
    @(posedge clk);
    #1;

    // Directed cases.
    send_op(2'b00, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001);
    send_op(2'b01, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001);
    send_op(2'b01, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001);
    send_op(2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
    send_op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
    send_op(2'b11, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001);
    send_op(2'b11, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007);
    send_op(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    send_op(2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    send_op(2'b01, 64'h1234_5678_0000_0000, 64'h0000_0001_0000_0001);

    // Random ops with idle gaps.
    for (int k = 0; k < 8; k++) begin
      send_op(2'($urandom_range(0, 3)),
              {$urandom, $urandom}, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Backpressure: hold o_ready low for 5 cycles in RSP.
    o_ready = 1'b0;
    e_bp    = model(2'b10, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000);
    send_op(2'b10, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_o_valid", {63'd0, o_valid}, 64'd1);
      check("bp_o_res", o_res, e_bp.res);
      check("bp_o_ov", {63'd0, o_ov}, {63'd0, e_bp.ov});
      check("bp_i_ready", {63'd0, i_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_after_i_ready", {63'd0, i_ready}, 64'd1);
    check("bp_after_o_valid", {63'd0, o_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Flush in HI with a beat presented: beat dropped, back to beat 0.
    beat(2'b00, 32'hAAAA_AAAA, 32'h1111_1111, ok);
    i_valid = 1'b1;
    i_rs1   = 32'h5555_5555;
    i_rs2   = 32'h2222_2222;
    flush   = 1'b1;
    @(negedge clk);
    check("flush_i_ready", {63'd0, i_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_no_o_valid", {63'd0, o_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    send_op(2'b01, 64'h0000_0010_0000_0003, 64'h0000_0001_0000_0004);

    // Reset while in RSP.
    o_ready = 1'b0;
    send_op(2'b00, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("rst_rsp_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_rsp_o_res", o_res, 64'd0);
    check("rst_rsp_o_ov", {63'd0, o_ov}, 64'd0);
    check("rst_rsp_i_ready", {63'd0, i_ready}, 64'd1);
    o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_e203_exu_dsp_add64
`default_nettype wire
